// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared constants and types for the K=7, rate-1/2 convolutional
//           encoder (generators 171/133 octal, 64-state trellis).
// Revision: 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Constraint length and encoder memory depth
    localparam int K        = 7;
    localparam int MEM      = K - 1;

    // Generator polynomials; bit 6 taps the current input, bit 0 the oldest bit
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;

    // Number of zero bits flushed after a frame to return the trellis to state 0
    localparam int TAIL_LEN = MEM;

    // Encoder control states
    typedef enum logic [0:0] {
        ACTIVE = 1'b0,
        TAIL   = 1'b1
    } enc_state_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_enc_pair.sv
`default_nettype none
// ============================================================================
// Module  : conv_enc_pair
// Brief   : Combinational trellis step: from input bit u and shift state s,
//           produce the {G0,G1} code pair and the successor state.
// Revision: 1.0 - initial release
// ============================================================================
module conv_enc_pair
    import conv_pkg::*;
(
    input  logic           u,
    input  logic [MEM-1:0] s,
    output logic [1:0]     pair,
    output logic [MEM-1:0] next_s
);

    // Full register window: bit 6 = current input, bit 0 = oldest stored bit
    logic [K-1:0] window;

    // Each output is the parity of the window masked by its generator
    always_comb begin
        window = {u, s};
        pair   = {^(window & G0), ^(window & G1)};
        next_s = {u, s[MEM-1:1]};
    end

endmodule : conv_enc_pair
`default_nettype wire

// File: rtl/conv_encoder_k7.sv
`default_nettype none
// ============================================================================
// Module  : conv_encoder_k7
// Brief   : Streaming rate-1/2, K=7 convolutional encoder with valid/ready
//           handshakes, registered output and optional 6-bit zero tail.
// Revision: 1.0 - initial release
// ============================================================================
module conv_encoder_k7
    import conv_pkg::*;
#(
    parameter int unsigned TERMINATE = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] tx_pair,
    output logic       out_last,
    output logic       busy
);

    localparam bit TERM_EN = (TERMINATE != 0);

    enc_state_t     state;
    enc_state_t     state_nxt;
    logic [MEM-1:0] s;
    logic [2:0]     tail_cnt;
    logic           adv;
    logic           accept;
    logic           tail_done;
    logic           enc_u;
    logic [1:0]     pair;
    logic [MEM-1:0] next_s;

    // Output slot can take a new pair when empty or being drained this cycle
    assign adv       = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign tail_done = (tail_cnt == 3'(TAIL_LEN - 1));
    // Tail bits are zeros, so the shared trellis step sees u=0 in TAIL
    assign enc_u     = (state == TAIL) ? 1'b0 : in_bit;

    conv_enc_pair u_pair (
        .u      (enc_u),
        .s      (s),
        .pair   (pair),
        .next_s (next_s)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACTIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter TAIL after a terminated frame, leave after the 6th tail pair
    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE: begin
                if (accept && in_last && TERM_EN) begin
                    state_nxt = TAIL;
                end
            end
            TAIL: begin
                if (adv && tail_done) begin
                    state_nxt = ACTIVE;
                end
            end
            default: state_nxt = ACTIVE;
        endcase
    end

    // Handshake and status outputs; ready has no path from in_valid
    always_comb begin
        in_ready = rst_n & (state == ACTIVE) & adv;
        busy     = (state == TAIL) | out_valid;
    end

    // Shift state, tail counter and registered output pair; all hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            tail_cnt  <= 3'd0;
            tx_pair   <= 2'b00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (state == ACTIVE) begin
            if (accept) begin
                tx_pair   <= pair;
                out_valid <= 1'b1;
                tail_cnt  <= 3'd0;
                if (in_last && !TERM_EN) begin
                    // Unterminated frame: close it here and restart from state 0
                    out_last <= 1'b1;
                    s        <= '0;
                end else begin
                    out_last <= 1'b0;
                    s        <= next_s;
                end
            end else if (adv) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end else if (adv) begin
            tx_pair   <= pair;
            out_valid <= 1'b1;
            s         <= next_s;
            out_last  <= tail_done;
            tail_cnt  <= tail_done ? 3'd0 : (tail_cnt + 3'd1);
        end
    end

endmodule : conv_encoder_k7
`default_nettype wire
